// File: rtl/pool_tile_glb_writer.sv
// Drains one padded tile from pool memory into the GLB at base + row*pitch + col.
// Define TILE_CNT_CHECK_EN to build the captured-pixel count check behind cnt_err.
module pool_tile_glb_writer #(
    parameter int DATA_WID = 128,
    parameter int GLB_AW   = 12
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                pad_end,
    input  logic [GLB_AW-1:0]   tile_base_addr,
    input  logic [GLB_AW-1:0]   row_pitch,
    output logic                glb_req,
    input  logic                glb_gnt,
    output logic                tile_dump,
    input  logic                tile_valid,
    input  logic [DATA_WID-1:0] tile_pixel,
    input  logic                dump_end,
    input  logic [4:0]          dump_length,
    input  logic [4:0]          dump_height,
    output logic                glb_wr_en,
    output logic [GLB_AW-1:0]   glb_wr_addr,
    output logic [DATA_WID-1:0] glb_wr_data,
    output logic                tile_done,
    output logic                cnt_err,
    output logic [5:0]          dbg_state_o
);

    // Handshakes: glb_req is held from REQ until DONE and the arbiter keeps glb_gnt
    // high until it drops; tile_dump is a single-cycle request; a stream beat is
    // taken on every tile_valid=1 cycle (the first one after tile_dump is a dummy).
    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        REQ    = 6'b000010,
        DUMP   = 6'b000100,
        LEAD   = 6'b001000,
        STREAM = 6'b010000,
        DONE   = 6'b100000
    } state_e;

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  flush_q, flush_d;
    logic [GLB_AW-1:0]     row_base_q, row_base_d;
    logic [GLB_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [GLB_AW-1:0]     pitch_q, pitch_d;
    logic [4:0]            len_q, len_d;
    logic [4:0]            col_q, col_d;
    logic                  wr_en_q, wr_en_d;
    logic [GLB_AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WID-1:0]   wr_data_q, wr_data_d;

    logic                  capture;
    logic                  row_end;
    logic [4:0]            len_eff;
    logic [GLB_AW-1:0]     next_row_base;

    // flush_q marks the cycle between the final capture and DONE, so tile_done
    // trails the last GLB write by one cycle.
    assign capture       = (state_q == STREAM) && tile_valid && !flush_q;
    assign len_eff       = (len_q == 5'd0) ? 5'd1 : len_q;
    assign row_end       = (col_q == len_eff - 5'd1);
    assign next_row_base = row_base_q + pitch_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | pad_end;
        flush_d    = flush_q;
        row_base_d = row_base_q;
        wr_ptr_d   = wr_ptr_q;
        pitch_d    = pitch_q;
        len_d      = len_q;
        col_d      = col_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = REQ;
                    pending_d = pad_end;
                end
            end
            REQ: begin
                if (glb_gnt) begin
                    state_d    = DUMP;
                    row_base_d = tile_base_addr;
                    wr_ptr_d   = tile_base_addr;
                    pitch_d    = row_pitch;
                end
            end
            DUMP: state_d = LEAD;
            LEAD: begin
                if (tile_valid) begin
                    state_d = STREAM;
                    len_d   = dump_length;
                    col_d   = 5'd0;
                    flush_d = 1'b0;
                end
            end
            STREAM: begin
                if (flush_q) begin
                    state_d = DONE;
                end else if (capture) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = tile_pixel;
                    if (row_end) begin
                        col_d      = 5'd0;
                        row_base_d = next_row_base;
                        wr_ptr_d   = next_row_base;
                    end else begin
                        col_d    = col_q + 5'd1;
                        wr_ptr_d = wr_ptr_q + GLB_AW'(1);
                    end
                    if (dump_end) flush_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            flush_q    <= 1'b0;
            row_base_q <= '0;
            wr_ptr_q   <= '0;
            pitch_q    <= '0;
            len_q      <= '0;
            col_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            row_base_q <= row_base_d;
            wr_ptr_q   <= wr_ptr_d;
            pitch_q    <= pitch_d;
            len_q      <= len_d;
            col_q      <= col_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign glb_req     = (state_q == REQ) || (state_q == DUMP) ||
                         (state_q == LEAD) || (state_q == STREAM);
    assign tile_dump   = (state_q == DUMP);
    assign tile_done   = (state_q == DONE);
    assign glb_wr_en   = wr_en_q;
    assign glb_wr_addr = wr_addr_q;
    assign glb_wr_data = wr_data_q;
    assign dbg_state_o = state_q;

`ifdef TILE_CNT_CHECK_EN
    logic [4:0] hgt_q, hgt_d;
    logic [9:0] pix_cnt_q, pix_cnt_d;
    logic       cnt_err_q, cnt_err_d;
    logic [9:0] tile_area;

    assign tile_area = {5'd0, len_q} * {5'd0, hgt_q};

    always_comb begin
        hgt_d     = hgt_q;
        pix_cnt_d = pix_cnt_q;
        cnt_err_d = cnt_err_q;
        if ((state_q == LEAD) && tile_valid) begin
            hgt_d     = dump_height;
            pix_cnt_d = 10'd0;
        end else if (capture) begin
            pix_cnt_d = pix_cnt_q + 10'd1;
            if (dump_end && (pix_cnt_q + 10'd1 != tile_area)) cnt_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hgt_q     <= '0;
            pix_cnt_q <= '0;
            cnt_err_q <= 1'b0;
        end else begin
            hgt_q     <= hgt_d;
            pix_cnt_q <= pix_cnt_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign cnt_err = cnt_err_q;
`else
    logic unused_dump_height;
    assign unused_dump_height = ^dump_height;
    assign cnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pool_tile_glb_writer.sv
// Bench for pool_tile_glb_writer: random tiles against an address/count model
// built from the raster rule base + row*pitch + col (mod 2^12).
module tb_pool_tile_glb_writer;

    localparam int AW = 12;
    localparam int DW = 128;
    localparam logic [5:0] ST_IDLE = 6'b000001;

    logic          clock;
    logic          rst_n;
    logic          pad_end;
    logic [AW-1:0] tile_base_addr;
    logic [AW-1:0] row_pitch;
    logic          glb_req;
    logic          glb_gnt;
    logic          tile_dump;
    logic          tile_valid;
    logic [DW-1:0] tile_pixel;
    logic          dump_end;
    logic [4:0]    dump_length;
    logic [4:0]    dump_height;
    logic          glb_wr_en;
    logic [AW-1:0] glb_wr_addr;
    logic [DW-1:0] glb_wr_data;
    logic          tile_done;
    logic          cnt_err;
    logic [5:0]    dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] act_q[$];
    logic          exp_cnt_err = 1'b0;
    logic [AW-1:0] tb_base;
    logic [AW-1:0] tb_pitch;

    pool_tile_glb_writer #(.DATA_WID(DW), .GLB_AW(AW)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .pad_end        (pad_end),
        .tile_base_addr (tile_base_addr),
        .row_pitch      (row_pitch),
        .glb_req        (glb_req),
        .glb_gnt        (glb_gnt),
        .tile_dump      (tile_dump),
        .tile_valid     (tile_valid),
        .tile_pixel     (tile_pixel),
        .dump_end       (dump_end),
        .dump_length    (dump_length),
        .dump_height    (dump_height),
        .glb_wr_en      (glb_wr_en),
        .glb_wr_addr    (glb_wr_addr),
        .glb_wr_data    (glb_wr_data),
        .tile_done      (tile_done),
        .cnt_err        (cnt_err),
        .dbg_state_o    (dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (glb_wr_en === 1'b1) begin
            act_q.push_back({glb_wr_addr, glb_wr_data});
            last_wr_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_pix();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic recover();
        rst_n = 1'b0;
        glb_gnt = 1'b0;
        tile_valid = 1'b0;
        dump_end = 1'b0;
        pad_end = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        exp_cnt_err = 1'b0;
        exp_q.delete();
        act_q.delete();
    endtask

    // driver: pad_end pulse, wait for request, grant after gnt_delay cycles
    task automatic start_tile(input bit do_pad, input int gnt_delay,
                              input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                              output bit ok);
        bit bad;
        int w;
        ok = 1'b1;
        bad = 1'b0;
        w = 0;
        tb_base = base;
        tb_pitch = pitch;
        tile_base_addr = base;
        row_pitch = pitch;
        if (do_pad) begin
            @(negedge clock);
            pad_end = 1'b1;
            @(negedge clock);
            pad_end = 1'b0;
            n_cmp++;
            if (glb_req !== 1'b0) begin
                n_fail++;
                $display("FAIL req_early: glb_req=%b required 0", glb_req);
            end
            @(negedge clock);
        end else begin
            while (glb_req !== 1'b1 && w < 50) begin
                @(negedge clock);
                w++;
            end
        end
        n_cmp++;
        if (glb_req !== 1'b1) begin
            n_fail++;
            ok = 1'b0;
            $display("FAIL req_rise: glb_req=%b required 1", glb_req);
        end else begin
            repeat (gnt_delay) begin
                if (glb_req !== 1'b1 || tile_dump !== 1'b0) bad = 1'b1;
                @(negedge clock);
            end
            if (glb_req !== 1'b1 || tile_dump !== 1'b0) bad = 1'b1;
            n_cmp++;
            if (bad) begin
                n_fail++;
                $display("FAIL gnt_wait: req/dump=%b%b required 10 while ungranted", glb_req, tile_dump);
            end
            glb_gnt = 1'b1;
            @(negedge clock);
            n_cmp++;
            if (tile_dump !== 1'b1) begin
                n_fail++;
                ok = 1'b0;
                $display("FAIL dump_after_gnt: tile_dump=%b required 1", tile_dump);
            end
        end
    endtask

    // driver: lead cycle then npix pixels with random idle gaps; fills exp_q
    task automatic stream_tile(input int len, input int hgt, input int npix, input int pad_at);
        int le;
        logic [DW-1:0] p;
        logic [AW-1:0] a;
        le = (len == 0) ? 1 : len;
        @(negedge clock);
        n_cmp++;
        if (tile_dump !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_one_cycle: tile_dump=%b required 0", tile_dump);
        end
        tile_valid = 1'b1;
        tile_pixel = rand_pix();
        dump_length = 5'(len);
        dump_height = 5'(hgt);
        dump_end = 1'b0;
        for (int i = 0; i < npix; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clock);
                tile_valid = 1'b0;
                tile_pixel = rand_pix();
                dump_end = 1'b0;
                pad_end = 1'b0;
            end
            @(negedge clock);
            p = rand_pix();
            a = AW'(int'(tb_base) + (i / le) * int'(tb_pitch) + (i % le));
            tile_valid = 1'b1;
            tile_pixel = p;
            dump_end = (i == npix - 1);
            pad_end = (i == pad_at);
            exp_q.push_back({a, p});
        end
        @(negedge clock);
        tile_valid = 1'b0;
        dump_end = 1'b0;
        pad_end = 1'b0;
`ifdef TILE_CNT_CHECK_EN
        if (npix != len * hgt) exp_cnt_err = 1'b1;
`endif
    endtask

    // scoreboard: wait for tile_done, then check timing, writes, cnt_err
    task automatic finish_tile(input string name);
        int w;
        w = 0;
        while (tile_done !== 1'b1 && w < 60) begin
            @(negedge clock);
            w++;
        end
        n_cmp++;
        if (tile_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: tile_done=%b required 1", name, tile_done);
        end else begin
            n_cmp++;
            if (cyc != last_wr_cyc + 1) begin
                n_fail++;
                $display("FAIL %s done_timing: done at %0d required %0d", name, cyc, last_wr_cyc + 1);
            end
            n_cmp++;
            if (glb_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s req_drop: glb_req=%b required 0", name, glb_req);
            end
        end
        glb_gnt = 1'b0;
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s wr_count: got %0d required %0d", name, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s wr[%0d]: addr=%h data=%h required addr=%h data=%h", name, i,
                         act_q[i][AW+DW-1:DW], act_q[i][DW-1:0], exp_q[i][AW+DW-1:DW], exp_q[i][DW-1:0]);
            end
        end
        n_cmp++;
        if (cnt_err !== exp_cnt_err) begin
            n_fail++;
            $display("FAIL %s cnt_err: got %b required %b", name, cnt_err, exp_cnt_err);
        end
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({glb_req, tile_dump, glb_wr_en, tile_done, cnt_err, glb_wr_addr, glb_wr_data, dbg_state} !==
            {5'b0, {AW{1'b0}}, {DW{1'b0}}, ST_IDLE}) begin
            n_fail++;
            $display("FAIL reset_values: req=%b dump=%b wr=%b done=%b err=%b addr=%h st=%b required all 0, st=%b",
                     glb_req, tile_dump, glb_wr_en, tile_done, cnt_err, glb_wr_addr, dbg_state, ST_IDLE);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (glb_req !== 1'b0 || glb_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: req=%b wr=%b required 0 0", glb_req, glb_wr_en);
        end
    endtask

    task automatic test_basic();
        bit ok;
        start_tile(1'b1, 2, 12'h100, 12'd16, ok);
        if (ok) begin
            stream_tile(4, 3, 12, -1);
            finish_tile("basic");
        end else recover();
    endtask

    task automatic test_grant_delay();
        bit ok;
        start_tile(1'b1, 20, 12'h300, 12'd5, ok);
        if (ok) begin
            stream_tile(2, 2, 4, -1);
            finish_tile("gnt_delay");
        end else recover();
    endtask

    task automatic test_overlap();
        bit ok;
        bit bad;
        start_tile(1'b1, 1, 12'h020, 12'd7, ok);
        if (!ok) begin
            recover();
            return;
        end
        stream_tile(3, 2, 6, 2);
        finish_tile("overlap1");
        @(negedge clock);
        n_cmp++;
        if (glb_req !== 1'b0 || tile_done !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_idle: req=%b done=%b required 0 0", glb_req, tile_done);
        end
        @(negedge clock);
        n_cmp++;
        if (glb_req !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_rereq: glb_req=%b required 1", glb_req);
        end
        start_tile(1'b0, 2, 12'h500, 12'd3, ok);
        if (!ok) begin
            recover();
            return;
        end
        stream_tile(2, 2, 4, -1);
        finish_tile("overlap2");
        bad = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (glb_req !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad || act_q.size() != 0) begin
            n_fail++;
            $display("FAIL overlap_third: extra req=%b writes=%0d required 0 0", bad, act_q.size());
        end
        act_q.delete();
    endtask

    task automatic test_random_tiles();
        bit ok;
        bit pend;
        pend = 1'b0;
        for (int t = 0; t < 6; t++) begin
            int len;
            int hgt;
            int np;
            int pad_at;
            len = $urandom_range(0, 6);
            hgt = $urandom_range(0, 4);
            np = ((len == 0) ? 1 : len) * ((hgt == 0) ? 1 : hgt);
            pad_at = -1;
            if (t < 5) begin
                case ($urandom_range(0, 2))
                    0: pad_at = np - 1;
                    1: pad_at = np / 2;
                    default: pad_at = -1;
                endcase
            end
            start_tile(!pend, $urandom_range(0, 3), AW'($urandom_range(0, 4095)),
                       AW'($urandom_range(0, 64)), ok);
            if (!ok) begin
                recover();
                return;
            end
            stream_tile(len, hgt, np, pad_at);
            finish_tile("random");
            pend = (pad_at >= 0);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        start_tile(1'b1, 0, 12'hFF8, 12'd8, ok);
        if (ok) begin
            stream_tile(2, 2, 4, -1);
            finish_tile("wrap");
        end else recover();
    endtask

    task automatic test_short_stream();
        bit ok;
        start_tile(1'b1, 1, 12'h200, 12'd16, ok);
        if (ok) begin
            stream_tile(5, 5, 20, -1);
            finish_tile("short");
        end else recover();
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit bad;
        start_tile(1'b1, 0, 12'h040, 12'd10, ok);
        if (ok) begin
            @(negedge clock);
            tile_valid = 1'b1;
            tile_pixel = rand_pix();
            dump_length = 5'd4;
            dump_height = 5'd4;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                tile_pixel = rand_pix();
            end
            @(negedge clock);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({glb_req, tile_dump, glb_wr_en, tile_done, cnt_err, glb_wr_addr, glb_wr_data, dbg_state} !==
            {5'b0, {AW{1'b0}}, {DW{1'b0}}, ST_IDLE}) begin
            n_fail++;
            $display("FAIL midreset_values: req=%b dump=%b wr=%b done=%b err=%b addr=%h st=%b required all 0, st=%b",
                     glb_req, tile_dump, glb_wr_en, tile_done, cnt_err, glb_wr_addr, dbg_state, ST_IDLE);
        end
        exp_cnt_err = 1'b0;
        glb_gnt = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        exp_q.delete();
        act_q.delete();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tile_valid = 1'b1;
            tile_pixel = rand_pix();
            dump_end = (i == 7);
            @(negedge clock);
            if (glb_req !== 1'b0 || tile_dump !== 1'b0) bad = 1'b1;
        end
        tile_valid = 1'b0;
        dump_end = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (bad || act_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: activity=%b writes=%0d required 0 0", bad, act_q.size());
        end
        act_q.delete();
        start_tile(1'b1, 1, 12'h7F0, 12'd9, ok);
        if (ok) begin
            stream_tile(3, 3, 9, -1);
            finish_tile("after_reset");
        end else recover();
    endtask

    initial begin
        rst_n = 1'b0;
        pad_end = 1'b0;
        glb_gnt = 1'b0;
        tile_valid = 1'b0;
        tile_pixel = '0;
        dump_end = 1'b0;
        dump_length = '0;
        dump_height = '0;
        tile_base_addr = '0;
        row_pitch = '0;
        tb_base = '0;
        tb_pitch = '0;
        test_reset();
        test_basic();
        test_grant_delay();
        test_overlap();
        test_random_tiles();
        test_wrap();
        test_short_stream();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_tile_glb_writer.md
# pool_tile_glb_writer

Consumer end of the pool-memory tile dump interface. After the pooling memory signals a fully padded tile (`pad_end`), the block:
- arbitrates for the global buffer (GLB) write port;
- issues a one-cycle `tile_dump` request and captures the raster-order pixel stream;
- writes each pixel to GLB at `tile_base_addr + row*row_pitch + col`.

It sits between the pooling memory and the GLB write arbiter.

## Interface
- `DATA_WID`, 128, pixel word width (8 lanes x 16 bit)
- `GLB_AW`, 12, GLB word-address width
- `clock` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous, active-low
- `pad_end` in 1, one-cycle pulse: padded tile ready in pool memory
- `tile_base_addr` in GLB_AW, GLB word address of pixel (0,0); sampled at REQ->DUMP
- `row_pitch` in GLB_AW, GLB words between rows; sampled at REQ->DUMP
- `glb_req` out 1, GLB write-port request
- `glb_gnt` in 1, GLB write-port grant; once granted, held by arbiter until `glb_req` drops
- `tile_dump` out 1, one-cycle dump request to pool memory
- `tile_valid` in 1, dump stream valid (includes one leading dummy cycle)
- `tile_pixel` in DATA_WID, dump stream data
- `dump_end` in 1, high with the last pixel of the stream
- `dump_length` in 5, tile width in pixels; valid from the lead cycle
- `dump_height` in 5, tile height in pixels; valid from the lead cycle
- `glb_wr_en` out 1, GLB write strobe
- `glb_wr_addr` out GLB_AW, GLB write address
- `glb_wr_data` out DATA_WID, GLB write data
- `tile_done` out 1, one-cycle pulse after the last GLB write
- `cnt_err` out 1, sticky: captured pixel count != length*height

## Operation
- **Pending flag**: set by `pad_end`, cleared on the IDLE->REQ transition.
  - If `pad_end` arrives while not IDLE, it stays pending and is serviced after DONE.
  - One flag only: a second `pad_end` before service is absorbed.
- **States** (one-hot):
  - IDLE: pending -> REQ, with `glb_req`=1.
  - REQ: `glb_gnt`=1 -> DUMP; latch `tile_base_addr` into `row_base` and `wr_ptr`, latch `row_pitch`.
  - DUMP: `tile_dump`=1 for exactly this cycle -> LEAD.
  - LEAD: wait for the first `tile_valid`=1 cycle. That cycle's data is discarded. Latch `dump_length` into `len` and `dump_height` into `hgt`, clear `col`/`row`/`pix_cnt` -> STREAM.
  - STREAM: each `tile_valid`=1 cycle captures `tile_pixel` at address `wr_ptr`.
    - Column step: `col++`, `wr_ptr++`.
    - End of row (`col == len-1`): `col`=0, `row++`, `row_base += row_pitch`, `wr_ptr = row_base + row_pitch`.
    - `dump_end`=1 on a captured cycle -> DONE.
    - `tile_valid`=0 cycles in STREAM are ignored (no write).
  - DONE: `tile_done`=1 and `glb_req`=0 for one cycle -> IDLE.
- **Addressing**: counter-based, no multiplier. Address arithmetic is modulo 2^GLB_AW; wrap is silent.
- **Degenerate tile**: `len`=0 or `hgt`=0 is treated as 1 for the end-of-row compare.
- **Reset**: asynchronous at any point, including mid-stream. FSM returns to IDLE, the pending flag clears and the in-flight tile is abandoned.

## Timing
- Reset values: `glb_req`=0, `tile_dump`=0, `glb_wr_en`=0, `glb_wr_addr`=0, `glb_wr_data`=0, `tile_done`=0, `cnt_err`=0.
- `pad_end` at edge k: REQ entered at k+1, so `glb_req` is high from k+1. Granted at edge g: `tile_dump` is high in cycle g+1.
- The pool memory raises `tile_valid` the cycle after `tile_dump`.
  - That cycle is the lead (dummy).
  - Pixel i follows in lead+1+i.
  - `dump_end` is high with pixel N-1.
- GLB write latency is 1 cycle: pixel captured at edge t gives `glb_wr_en`/addr/data registered at t, visible in cycle t+1. The GLB port is never stalled.
- `tile_done` is high the cycle after the last `glb_wr_en`.
- `glb_req` drops with `tile_done`; back-to-back tiles need at least 1 IDLE cycle.
- If `dump_end` and a pending `pad_end` occur on the same edge, the pending flag is set; the next REQ follows DONE+IDLE.

## Configuration
- `TILE_CNT_CHECK_EN` defined:
  - A 10-bit `pix_cnt` counts captured pixels.
  - At `dump_end`, if `pix_cnt+1 != len*hgt` (10-bit product), `cnt_err` is set.
  - `cnt_err` clears only on reset.
- `TILE_CNT_CHECK_EN` undefined: no counter or multiplier is built and `cnt_err` is tied 0. The port remains.

## Test plan
- **Basic 4x3 tile**: `pad_end`, base=0x100, pitch=16, `glb_gnt` 2 cycles after req.
  - Required: 12 writes to 0x100-0x103, 0x110-0x113, 0x120-0x123 in raster order; lead data not written.
  - Required: `tile_done` one cycle after the write to 0x123; `cnt_err`=0.
- **Grant delay**: `glb_gnt` held low 20 cycles.
  - Required: `glb_req` high throughout, `tile_dump` not issued until 1 cycle after grant.
- **Overlapping request**: second `pad_end` during STREAM.
  - Required: second REQ only after `tile_done` plus one IDLE cycle; exactly 2 tiles written.
- **Short stream**: 5x5 header but `dump_end` after 20 pixels.
  - Required: 20 writes, `tile_done`; with macro `cnt_err`=1, without it `cnt_err`=0.
- **Address wrap**: base=0xFF8, pitch=8, 2x2 tile.
  - Required: writes to 0xFF8, 0xFF9, 0x000, 0x001.
- **Reset mid-stream**: `rst_n` low after pixel 3.
  - Required: all outputs 0 immediately, FSM in IDLE.
  - Required: no writes until a new `pad_end`; next tile completes normally.
